// File: rtl/sar_search_ctrl_if.sv
// Comparator-loop bundle for the SAR search controller.
// master: the controller (drives trial and status); slave: comparator/requester side.
interface sar_search_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] trial;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             eq_hit;
  logic             err;

  modport master (
    input  start, cmp_gt, cmp_eq, cmp_lt,
    output trial, busy, done, result, eq_hit, err
  );

  modport slave (
    output start, cmp_gt, cmp_eq, cmp_lt,
    input  trial, busy, done, result, eq_hit, err
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives a comparator's b operand and
// binary-searches MSB-first, one bit per clock, for the comparator's a operand.
// Optional feature macro: SAR_EARLY_EXIT_EN (finish as soon as cmp_eq is seen).
module sar_search_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sar_search_ctrl_if.master bus
);

  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB_MASK = WIDTH'(1);

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             eq_hit_q, eq_hit_d;
  logic             err_q, err_d;

  logic             flags_ok_c;
  logic             bit_set_c;
  logic             early_c;
  logic [WIDTH-1:0] trial_c;

  // Trial operand is combinational so the external comparator settles within the cycle.
  assign trial_c = (state_q == SEARCH) ? (acc_q | mask_q) : '0;

  // Comparator flags must be exactly one-hot; anything else is an error step treated as lt.
  assign flags_ok_c = ( bus.cmp_gt & ~bus.cmp_eq & ~bus.cmp_lt) |
                      (~bus.cmp_gt &  bus.cmp_eq & ~bus.cmp_lt) |
                      (~bus.cmp_gt & ~bus.cmp_eq &  bus.cmp_lt);
  assign bit_set_c  = flags_ok_c & (bus.cmp_gt | bus.cmp_eq);

`ifdef SAR_EARLY_EXIT_EN
  assign early_c = flags_ok_c & bus.cmp_eq;
`else
  assign early_c = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mask_d   = mask_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    eq_hit_d = eq_hit_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SEARCH;
          acc_d    = '0;
          mask_d   = MSB_MASK;
          busy_d   = 1'b1;
          eq_hit_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      SEARCH: begin
        acc_d    = bit_set_c ? (acc_q | mask_q) : acc_q;
        eq_hit_d = eq_hit_q | bus.cmp_eq;
        mask_d   = mask_q >> 1;
        if (!flags_ok_c) begin
          err_d = 1'b1;
        end
        // On an early exit acc_d already equals the trial value (eq sets the current bit).
        if (early_c || (mask_q == LSB_MASK)) begin
          result_d = acc_d;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mask_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      eq_hit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mask_q   <= mask_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      eq_hit_q <= eq_hit_d;
      err_q    <= err_d;
    end
  end

  assign bus.trial  = trial_c;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.eq_hit = eq_hit_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl (WIDTH=4) with a behavioural comparator.
module tb_sar_search_ctrl;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] target;
  logic         force_bad;
  int           errors;
  int           checks;

  sar_search_ctrl_if #(.WIDTH(W)) bus ();

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator: a = target, b = trial; force_bad drives an illegal gt+lt pattern.
  always_comb begin
    bus.cmp_gt = (target > bus.trial);
    bus.cmp_eq = (target == bus.trial);
    bus.cmp_lt = (target < bus.trial);
    if (force_bad) begin
      bus.cmp_gt = 1'b1;
      bus.cmp_eq = 1'b0;
      bus.cmp_lt = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: trial at a step keeps target bits above the probed bit and sets the probed bit.
  function automatic int model_trial(input int tgt, input int step);
    int b;
    b = int'(W) - 1 - step;
    return ((tgt >> (b + 1)) << (b + 1)) + (1 << b);
  endfunction

  // Reference latency: full width, or with early exit the step at which target's lowest 1 is probed.
  function automatic int model_latency(input int tgt);
    int lat;
    lat = int'(W);
`ifdef SAR_EARLY_EXIT_EN
    for (int b = int'(W) - 1; b >= 0; b--) begin
      if (((tgt >> b) & 1) == 1) lat = int'(W) - b;
    end
`endif
    return lat;
  endfunction

  // One full search from an idle (or done-cycle) start; bad = step with illegal flags, -1 for none.
  task automatic do_search(input int tgt, input int bad, input int exp_res, input int exp_eq,
                           input int exp_err, input int exp_lat, input string tag);
    int step;
    target = W'(tgt);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk($sformatf("%s busy_after_start", tag), int'(bus.busy), 1);
    chk($sformatf("%s done_after_start", tag), int'(bus.done), 0);
    chk($sformatf("%s err_cleared", tag), int'(bus.err), 0);
    chk($sformatf("%s eq_hit_cleared", tag), int'(bus.eq_hit), 0);
    step = 0;
    while (!bus.done && step <= int'(W)) begin
      if (bad < 0 || step <= bad)
        chk($sformatf("%s trial_step%0d", tag, step), int'(bus.trial), model_trial(tgt, step));
      force_bad = (step == bad);
      @(posedge clk); #1;
      force_bad = 1'b0;
      step++;
    end
    chk($sformatf("%s latency", tag), step, exp_lat);
    chk($sformatf("%s result", tag), int'(bus.result), exp_res);
    chk($sformatf("%s eq_hit", tag), int'(bus.eq_hit), exp_eq);
    chk($sformatf("%s err", tag), int'(bus.err), exp_err);
    chk($sformatf("%s busy_at_done", tag), int'(bus.busy), 0);
    chk($sformatf("%s trial_idle", tag), int'(bus.trial), 0);
  endtask

  typedef struct {
    int tgt;
    int bad;
    int exp_res;
    int exp_eq;
    int exp_err;
    int lat_def;
    int lat_early;
  } vec_t;

  vec_t vecs[8];

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    target    = '0;
    force_bad = 1'b0;
    bus.start = 1'b0;

    vecs[0] = '{11, -1, 11, 1, 0, 4, 4};
    vecs[1] = '{ 0, -1,  0, 0, 0, 4, 4};
    vecs[2] = '{15, -1, 15, 1, 0, 4, 4};
    vecs[3] = '{ 8, -1,  8, 1, 0, 4, 1};
    vecs[4] = '{12, -1, 12, 1, 0, 4, 2};
    vecs[5] = '{11,  1, 11, 1, 1, 4, 4};
    vecs[6] = '{11,  2,  9, 0, 1, 4, 4};
    vecs[7] = '{ 6, -1,  6, 1, 0, 4, 3};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst trial", int'(bus.trial), 0);
    chk("rst busy", int'(bus.busy), 0);
    chk("rst done", int'(bus.done), 0);
    chk("rst result", int'(bus.result), 0);
    chk("rst eq_hit", int'(bus.eq_hit), 0);
    chk("rst err", int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven directed searches
    foreach (vecs[i]) begin
`ifdef SAR_EARLY_EXIT_EN
      do_search(vecs[i].tgt, vecs[i].bad, vecs[i].exp_res, vecs[i].exp_eq, vecs[i].exp_err,
                vecs[i].lat_early, $sformatf("vec%0d", i));
`else
      do_search(vecs[i].tgt, vecs[i].bad, vecs[i].exp_res, vecs[i].exp_eq, vecs[i].exp_err,
                vecs[i].lat_def, $sformatf("vec%0d", i));
`endif
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // Start while busy is ignored; start in the done cycle is accepted
    target = W'(11);
    bus.start = 1'b1;
    @(posedge clk); #1;              // E0
    bus.start = 1'b0;
    @(posedge clk); #1;              // E0+1
    bus.start = 1'b1;
    @(posedge clk); #1;              // E0+2: must be ignored
    bus.start = 1'b0;
    chk("busy_ign busy", int'(bus.busy), 1);
    @(posedge clk); #1;              // E0+3
    chk("busy_ign no_early_done", int'(bus.done), 0);
    @(posedge clk); #1;              // E0+4
    chk("busy_ign done", int'(bus.done), 1);
    chk("busy_ign result", int'(bus.result), 11);
    chk("busy_ign busy_low", int'(bus.busy), 0);
    @(posedge clk); #1;
    chk("busy_ign single_done", int'(bus.done), 0);
    chk("busy_ign not_requeued", int'(bus.busy), 0);
    do_search(5, -1, 5, 1, 0, model_latency(5), "b2b_first");
    // bus is now in its done cycle; start here must be accepted
    do_search(13, -1, 13, 1, 0, model_latency(13), "b2b_done_cycle");

    // Reset mid-search
    target = W'(11);
    bus.start = 1'b1;
    @(posedge clk); #1;              // E0
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;              // just after E0+2
    rst_n = 1'b0;
    #1;
    chk("midrst trial", int'(bus.trial), 0);
    chk("midrst busy", int'(bus.busy), 0);
    chk("midrst done", int'(bus.done), 0);
    chk("midrst result", int'(bus.result), 0);
    chk("midrst eq_hit", int'(bus.eq_hit), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst no_done%0d", c), int'(bus.done), 0);
    end
    do_search(11, -1, 11, 1, 0, model_latency(11), "after_rst");

    // Randomized targets against the reference model
    for (int r = 0; r < 24; r++) begin
      int t;
      t = int'($urandom_range(0, (1 << W) - 1));
      do_search(t, -1, t, (t != 0) ? 1 : 0, 0, model_latency(t), $sformatf("rnd%0d_t%0d", r, t));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
